// File: rtl/log_shift_acc_if.sv
// rtl/log_shift_acc_if.sv - beat/result handshake bundle for the log-weight shift accumulator
interface log_shift_acc_if #(
    parameter int LANES = 4,
    parameter int ACT_W = 12,
    parameter int EXP_W = 3,
    parameter int ACC_W = 24
);
    logic                         i_valid;
    logic                         o_ready;
    logic                         i_skip;
    logic                         i_first;
    logic                         i_last;
    logic [LANES*(EXP_W+1)-1:0]   i_weight;
    logic [LANES*ACT_W-1:0]       i_activation;
    logic                         o_valid;
    logic                         i_out_ready;
    logic [ACC_W-1:0]             o_sum;
    logic                         o_ovf;

    modport master (
        output i_valid, i_skip, i_first, i_last, i_weight, i_activation, i_out_ready,
        input  o_ready, o_valid, o_sum, o_ovf
    );

    modport slave (
        input  i_valid, i_skip, i_first, i_last, i_weight, i_activation, i_out_ready,
        output o_ready, o_valid, o_sum, o_ovf
    );
endinterface

// File: rtl/log_shift_acc.sv
// rtl/log_shift_acc.sv - three-stage log-domain (shift) multiply-accumulate with saturating group sum
module log_shift_acc #(
    parameter int LANES = 4,
    parameter int ACT_W = 12,
    parameter int EXP_W = 3,
    parameter int ACC_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    log_shift_acc_if.slave  bus
);
    localparam int PROD_W = ACT_W + (1 << EXP_W) - 1;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    localparam int WGT_W  = EXP_W + 1;

    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    logic w_enable;
    logic w_accept;
    logic r_out_valid;

    // A held result with no downstream taker freezes the whole pipeline.
    assign w_enable = !(r_out_valid && !bus.i_out_ready);
    assign w_accept = bus.i_valid && w_enable;

    logic signed [PROD_W-1:0] w_prod [LANES];

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [EXP_W-1:0]  w_code;
            logic              w_neg;
            logic [PROD_W-1:0] w_act_ext;
            logic [PROD_W-1:0] w_mag;

            assign w_code    = bus.i_weight[g*WGT_W +: EXP_W];
            assign w_neg     = bus.i_weight[g*WGT_W + EXP_W];
            assign w_act_ext = {{(PROD_W-ACT_W){1'b0}}, bus.i_activation[g*ACT_W +: ACT_W]};
            assign w_mag     = (w_code == '0) ? '0 : (w_act_ext << (w_code - EXP_W'(1)));
            assign w_prod[g] = bus.i_skip ? '0 : (w_neg ? -w_mag : w_mag);
        end
    endgenerate

    logic signed [PROD_W-1:0] r_prod [LANES];
    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (w_enable) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_prod[i];
                end
                r_s1_first <= bus.i_first;
                r_s1_last  <= bus.i_last;
            end
        end
    end

    logic signed [SUM_W-1:0] w_lane_sum;

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + {{(SUM_W-PROD_W){r_prod[i][PROD_W-1]}}, r_prod[i]};
        end
    end

    logic signed [SUM_W-1:0] r_sum;
    logic                    r_s2_valid;
    logic                    r_s2_first;
    logic                    r_s2_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (w_enable) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum      <= w_lane_sum;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
            end
        end
    end

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_grp_ovf;
    logic [ACC_W-1:0]        r_out_sum;
    logic                    r_out_ovf;

    logic signed [ACC_W:0]   w_base;
    logic signed [ACC_W:0]   w_add;
    logic signed [ACC_W:0]   w_total;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic [ACC_W-1:0]        w_acc_next;
    logic                    w_ovf_next;

    // One extra bit of headroom so the clamp can see overflow in either direction.
    always_comb begin
        w_base     = r_s2_first ? '0 : {r_acc[ACC_W-1], r_acc};
        w_add      = {{(ACC_W+1-SUM_W){r_sum[SUM_W-1]}}, r_sum};
        w_total    = w_base + w_add;
        w_sat_hi   = (w_total > SAT_MAX);
        w_sat_lo   = (w_total < SAT_MIN);
        w_acc_next = w_sat_hi ? SAT_MAX[ACC_W-1:0] :
                     w_sat_lo ? SAT_MIN[ACC_W-1:0] : w_total[ACC_W-1:0];
        w_ovf_next = w_sat_hi || w_sat_lo || (!r_s2_first && r_grp_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_grp_ovf   <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_enable) begin
            r_out_valid <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                r_acc     <= w_acc_next;
                r_grp_ovf <= w_ovf_next;
                if (r_s2_last) begin
                    r_out_sum <= w_acc_next;
                    r_out_ovf <= w_ovf_next;
                end
            end
        end
    end

    assign bus.o_ready = w_enable;
    assign bus.o_valid = r_out_valid;
    assign bus.o_sum   = r_out_sum;
    assign bus.o_ovf   = r_out_ovf;
endmodule

// File: tb/tb_log_shift_acc.sv
// tb/tb_log_shift_acc.sv - directed bench with arithmetic group model and result scoreboard
module tb_log_shift_acc;
    localparam int LANES = 4;
    localparam int ACT_W = 12;
    localparam int EXP_W = 3;
    localparam int ACC_W = 24;
    localparam longint SAT_MAX = 8388607;
    localparam longint SAT_MIN = -8388608;

    localparam logic [15:0] W_A = 16'h0721;
    localparam logic [47:0] A_A = {12'd4095, 12'd1, 12'd100, 12'd100};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    log_shift_acc_if #(.LANES(LANES), .ACT_W(ACT_W), .EXP_W(EXP_W), .ACC_W(ACC_W)) bus ();

    log_shift_acc #(.LANES(LANES), .ACT_W(ACT_W), .EXP_W(EXP_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint sum;
        logic   ovf;
    } res_t;

    res_t   exp_q[$];
    longint m_acc = 0;
    logic   m_ovf = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint beat_sum(input logic [15:0] w, input logic [47:0] a, input logic skip);
        longint s;
        longint m;
        int     code;
        s = 0;
        if (skip) return 0;
        for (int i = 0; i < LANES; i++) begin
            code = int'(w[i*4 +: 3]);
            m = (code > 0) ? (longint'(a[i*12 +: 12]) << (code - 1)) : 0;
            if (w[i*4 + 3]) m = -m;
            s += m;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_acc = 0;
            m_ovf = 1'b0;
            exp_q.delete();
        end else if (bus.i_valid && bus.o_ready) begin
            longint t;
            t = beat_sum(bus.i_weight, bus.i_activation, bus.i_skip);
            if (bus.i_first) m_ovf = 1'b0;
            else t = m_acc + t;
            if (t > SAT_MAX) begin
                t = SAT_MAX;
                m_ovf = 1'b1;
            end else if (t < SAT_MIN) begin
                t = SAT_MIN;
                m_ovf = 1'b1;
            end
            m_acc = t;
            if (bus.i_last) exp_q.push_back('{t, m_ovf});
        end
    end

    longint held_sum;
    logic   held_ovf;
    logic   was_stalled = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (!rst && bus.o_valid) begin
            if (was_stalled) begin
                check("stall_hold_sum", $signed(bus.o_sum), held_sum);
                check("stall_hold_ovf", bus.o_ovf, held_ovf);
            end
            if (bus.i_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_sum", $signed(bus.o_sum), e.sum);
                    check("sb_ovf", bus.o_ovf, e.ovf);
                end
                was_stalled = 1'b0;
            end else begin
                was_stalled = 1'b1;
                held_sum = $signed(bus.o_sum);
                held_ovf = bus.o_ovf;
            end
        end else begin
            was_stalled = 1'b0;
        end
    end

    task automatic idle();
        bus.i_valid      = 1'b0;
        bus.i_skip       = 1'b0;
        bus.i_first      = 1'b0;
        bus.i_last       = 1'b0;
        bus.i_weight     = '0;
        bus.i_activation = '0;
    endtask

    task automatic send(input logic f, input logic l, input logic sk,
                        input logic [15:0] w, input logic [47:0] a);
        int n;
        bus.i_first      = f;
        bus.i_last       = l;
        bus.i_skip       = sk;
        bus.i_weight     = w;
        bus.i_activation = a;
        bus.i_valid      = 1'b1;
        n = 0;
        #1;
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.o_ready) check("accept_timeout", 0, 1);
        @(negedge clk);
        idle();
    endtask

    task automatic wait_result(input string name, input longint exp_sum, input logic exp_ovf);
        int n;
        n = 0;
        while (!bus.o_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.o_valid) begin
            check({name, "_sum"}, $signed(bus.o_sum), exp_sum);
            check({name, "_ovf"}, bus.o_ovf, exp_ovf);
        end else begin
            check({name, "_timeout"}, 0, 1);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        bus.i_out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_sum", bus.o_sum, 0);
        check("rst_o_ovf", bus.o_ovf, 0);
        check("rst_o_ready", bus.o_ready, 1);

        send(1, 1, 0, W_A, A_A);
        check("lat_c1", bus.o_valid, 0);
        @(negedge clk);
        check("lat_c2", bus.o_valid, 0);
        @(negedge clk);
        check("lat_c3", bus.o_valid, 1);
        check("single_sum", $signed(bus.o_sum), 364);
        check("single_ovf", bus.o_ovf, 0);
        @(negedge clk);

        send(1, 1, 0, 16'h000B, 48'd10);
        wait_result("neg_lane", -40, 1'b0);

        send(1, 0, 0, W_A, A_A);
        send(0, 0, 1, 16'hFFFF, 48'hFFFF_FFFF_FFFF);
        send(0, 1, 0, 16'h000B, 48'd10);
        wait_result("group3", 324, 1'b0);

        send(1, 1, 0, W_A, A_A);
        wait_result("held_base", 364, 1'b0);
        send(0, 1, 0, 16'h000B, 48'd10);
        wait_result("no_clear", 324, 1'b0);

        send(1, 1, 1, W_A, A_A);
        wait_result("skip_only", 0, 1'b0);

        for (int i = 0; i < 9; i++) send(i == 0, i == 8, 0, 16'h7777, {4{12'hFFF}});
        wait_result("sat_pos", 8388607, 1'b1);
        send(1, 1, 0, W_A, A_A);
        wait_result("ovf_clear", 364, 1'b0);

        for (int i = 0; i < 9; i++) send(i == 0, i == 8, 0, 16'hFFFF, {4{12'hFFF}});
        wait_result("sat_neg", -8388608, 1'b1);

        bus.i_out_ready = 1'b0;
        fork
            begin
                send(1, 1, 0, W_A, A_A);
                send(1, 1, 0, 16'h000B, 48'd10);
                send(1, 1, 0, 16'h0002, 48'd7);
                send(1, 1, 0, 16'h0007, 48'd3);
            end
            begin
                int n;
                n = 0;
                while (!bus.o_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) begin
                    #2;
                    check("stall_o_ready", bus.o_ready, 0);
                    check("stall_o_valid", bus.o_valid, 1);
                    @(negedge clk);
                end
                bus.i_out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);

        send(1, 0, 0, W_A, A_A);
        send(0, 0, 0, W_A, A_A);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            check("rst_flush_no_valid", bus.o_valid, 0);
            @(negedge clk);
        end
        send(1, 1, 0, 16'h000B, 48'd10);
        wait_result("post_rst", -40, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
